// File: rtl/game_sequencer_if.sv
// Port bundle between the game sequencer and its neighbours: the VGA timing
// generator (frame tick), the level renderer (collision strobes), the movement
// logic (position in, spawn/enable out) and the HUD (level, deaths, fade, win).
//   slave  : seen by game_sequencer (i_* in, o_* out)
//   master : seen by whoever drives the inputs and consumes the outputs
interface game_sequencer_if;
    logic       i_frame_tick;
    logic       i_start;
    logic       i_hit_lava;
    logic       i_hit_exit;
    logic       i_hit_checkpoint;
    logic [9:0] i_char_x;
    logic [9:0] i_char_y;
    logic [2:0] o_level;
    logic [2:0] o_state;
    logic       o_move_en;
    logic       o_spawn_load;
    logic [9:0] o_spawn_x;
    logic [9:0] o_spawn_y;
    logic [7:0] o_deaths;
    logic       o_fade;
    logic       o_win;

    modport slave (
        input  i_frame_tick, i_start, i_hit_lava, i_hit_exit, i_hit_checkpoint,
               i_char_x, i_char_y,
        output o_level, o_state, o_move_en, o_spawn_load, o_spawn_x, o_spawn_y,
               o_deaths, o_fade, o_win
    );

    modport master (
        output i_frame_tick, i_start, i_hit_lava, i_hit_exit, i_hit_checkpoint,
               i_char_x, i_char_y,
        input  o_level, o_state, o_move_en, o_spawn_load, o_spawn_x, o_spawn_y,
               o_deaths, o_fade, o_win
    );
endinterface

// File: rtl/game_sequencer.sv
// Frame-rate game state machine. Latches per-pixel collision strobes during a
// frame, evaluates them at the frame tick and drives level, movement enable,
// respawn loads, death counter and transition/win indicators.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : game_sequencer_if.slave (strobes/position in, game status out)
module game_sequencer #(
    parameter int NUM_LEVELS   = 4,
    parameter int DEATH_FRAMES = 16,
    parameter int TRANS_FRAMES = 32,
    parameter logic [9:0] SPAWN_X = 10'd304,
    parameter logic [9:0] SPAWN_Y = 10'd220
) (
    input  logic             clk,
    input  logic             rst,
    game_sequencer_if.slave  bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PLAY    = 3'd1;
    localparam logic [2:0] S_DYING   = 3'd2;
    localparam logic [2:0] S_TRANSIT = 3'd3;
    localparam logic [2:0] S_WIN     = 3'd4;

    localparam int CNT_MAX = (DEATH_FRAMES > TRANS_FRAMES) ? DEATH_FRAMES : TRANS_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DEATH_LAST = CNT_W'(DEATH_FRAMES - 1);
    localparam logic [CNT_W-1:0] TRANS_LAST = CNT_W'(TRANS_FRAMES - 1);
    localparam logic [2:0]       LAST_LVL   = 3'(NUM_LEVELS - 1);

    logic [2:0]       r_state, w_state;
    logic [2:0]       r_level, w_level;
    logic [7:0]       r_deaths, w_deaths;
    logic [9:0]       r_spawn_x, w_spawn_x;
    logic [9:0]       r_spawn_y, w_spawn_y;
    logic             r_spawn_load, w_spawn_load;
    logic             r_move_en, r_fade, r_win;
    logic             r_cp_valid, w_cp_valid;
    logic [9:0]       r_cp_x, w_cp_x;
    logic [9:0]       r_cp_y, w_cp_y;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic             r_start_q;
    logic             r_lava_l, r_exit_l, r_cp_l;

    logic w_start_rise, w_lava, w_exit, w_cp, w_collect;

    assign w_start_rise = bus.i_start & ~r_start_q;
    // Live strobe is OR-ed in so a hit landing on the tick cycle still counts.
    assign w_lava = r_lava_l | bus.i_hit_lava;
    assign w_exit = r_exit_l | bus.i_hit_exit;
    assign w_cp   = r_cp_l   | bus.i_hit_checkpoint;
    // Latches accumulate only inside a PLAY frame; the tick starts a fresh frame.
    assign w_collect = (r_state == S_PLAY) && !bus.i_frame_tick;

    always_comb begin
        w_state      = r_state;
        w_level      = r_level;
        w_deaths     = r_deaths;
        w_spawn_x    = r_spawn_x;
        w_spawn_y    = r_spawn_y;
        w_spawn_load = 1'b0;
        w_cp_valid   = r_cp_valid;
        w_cp_x       = r_cp_x;
        w_cp_y       = r_cp_y;
        w_cnt        = r_cnt;
        case (r_state)
            S_IDLE, S_WIN: begin
                if (w_start_rise) begin
                    w_state      = S_PLAY;
                    w_level      = 3'd0;
                    w_deaths     = 8'd0;
                    w_cp_valid   = 1'b0;
                    w_spawn_x    = SPAWN_X;
                    w_spawn_y    = SPAWN_Y;
                    w_spawn_load = 1'b1;
                end
            end
            S_PLAY: begin
                if (bus.i_frame_tick) begin
                    if (w_lava) begin
                        w_state  = S_DYING;
                        w_deaths = (r_deaths == 8'hFF) ? r_deaths : r_deaths + 8'd1;
                        w_cnt    = '0;
                    end else if (w_exit) begin
                        w_state = (r_level == LAST_LVL) ? S_WIN : S_TRANSIT;
                        w_cnt   = '0;
                    end else if (w_cp) begin
                        w_cp_valid = 1'b1;
                        w_cp_x     = bus.i_char_x;
                        w_cp_y     = bus.i_char_y;
                    end
                end
            end
            S_DYING: begin
                if (bus.i_frame_tick) begin
                    if (r_cnt == DEATH_LAST) begin
                        w_state      = S_PLAY;
                        w_spawn_load = 1'b1;
                        w_spawn_x    = r_cp_valid ? r_cp_x : SPAWN_X;
                        w_spawn_y    = r_cp_valid ? r_cp_y : SPAWN_Y;
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
            end
            S_TRANSIT: begin
                if (bus.i_frame_tick) begin
                    if (r_cnt == TRANS_LAST) begin
                        w_state      = S_PLAY;
                        w_level      = r_level + 3'd1;
                        w_cp_valid   = 1'b0;
                        w_spawn_load = 1'b1;
                        w_spawn_x    = SPAWN_X;
                        w_spawn_y    = SPAWN_Y;
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_level      <= 3'd0;
            r_deaths     <= 8'd0;
            r_spawn_x    <= SPAWN_X;
            r_spawn_y    <= SPAWN_Y;
            r_spawn_load <= 1'b0;
            r_move_en    <= 1'b0;
            r_fade       <= 1'b0;
            r_win        <= 1'b0;
            r_cp_valid   <= 1'b0;
            r_cp_x       <= 10'd0;
            r_cp_y       <= 10'd0;
            r_cnt        <= '0;
            r_start_q    <= 1'b1;  // a button held through reset is not a press
            r_lava_l     <= 1'b0;
            r_exit_l     <= 1'b0;
            r_cp_l       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_level      <= w_level;
            r_deaths     <= w_deaths;
            r_spawn_x    <= w_spawn_x;
            r_spawn_y    <= w_spawn_y;
            r_spawn_load <= w_spawn_load;
            r_move_en    <= (w_state == S_PLAY);
            r_fade       <= (w_state == S_TRANSIT);
            r_win        <= (w_state == S_WIN);
            r_cp_valid   <= w_cp_valid;
            r_cp_x       <= w_cp_x;
            r_cp_y       <= w_cp_y;
            r_cnt        <= w_cnt;
            r_start_q    <= bus.i_start;
            r_lava_l     <= w_collect & (r_lava_l | bus.i_hit_lava);
            r_exit_l     <= w_collect & (r_exit_l | bus.i_hit_exit);
            r_cp_l       <= w_collect & (r_cp_l   | bus.i_hit_checkpoint);
        end
    end

    assign bus.o_state      = r_state;
    assign bus.o_level      = r_level;
    assign bus.o_deaths     = r_deaths;
    assign bus.o_spawn_x    = r_spawn_x;
    assign bus.o_spawn_y    = r_spawn_y;
    assign bus.o_spawn_load = r_spawn_load;
    assign bus.o_move_en    = r_move_en;
    assign bus.o_fade       = r_fade;
    assign bus.o_win        = r_win;
endmodule

// File: tb/tb_game_sequencer.sv
module tb_game_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    game_sequencer_if bus ();

    game_sequencer #(
        .NUM_LEVELS(4), .DEATH_FRAMES(16), .TRANS_FRAMES(32),
        .SPAWN_X(10'd304), .SPAWN_Y(10'd220)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs set and outputs read 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bus.i_frame_tick = 1'b1;
        step();
        bus.i_frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Exit on the current level and ride the whole transition.
    task automatic exit_level();
        bus.i_hit_exit = 1'b1;
        tick();
        bus.i_hit_exit = 1'b0;
        ticks(32);
    endtask

    initial begin
        bus.i_frame_tick = 0; bus.i_start = 1; bus.i_hit_lava = 0;
        bus.i_hit_exit = 0; bus.i_hit_checkpoint = 0;
        bus.i_char_x = 10'd10; bus.i_char_y = 10'd20;
        rst = 1'b1;
        step(); step();
        chk("rst_state",  bus.o_state, 0);
        chk("rst_level",  bus.o_level, 0);
        chk("rst_deaths", bus.o_deaths, 0);
        chk("rst_move",   bus.o_move_en, 0);
        chk("rst_load",   bus.o_spawn_load, 0);
        chk("rst_sx",     bus.o_spawn_x, 304);
        chk("rst_sy",     bus.o_spawn_y, 220);
        chk("rst_fade",   bus.o_fade, 0);
        chk("rst_win",    bus.o_win, 0);
        rst = 1'b0;
        step(); step(); step();
        chk("held_start_idle", bus.o_state, 0);

        // Start edge
        bus.i_start = 0; step();
        bus.i_start = 1; step();
        chk("start_state", bus.o_state, 1);
        chk("start_level", bus.o_level, 0);
        chk("start_load",  bus.o_spawn_load, 1);
        chk("start_sx",    bus.o_spawn_x, 304);
        chk("start_sy",    bus.o_spawn_y, 220);
        chk("start_move",  bus.o_move_en, 1);
        step();
        chk("start_load_1cyc", bus.o_spawn_load, 0);
        bus.i_start = 0;

        // Lava strobe mid-frame, evaluated at the next tick
        step();
        bus.i_hit_lava = 1; step(); bus.i_hit_lava = 0;
        step(); step();
        chk("lava_wait_play", bus.o_state, 1);
        tick();
        chk("lava_state",  bus.o_state, 2);
        chk("lava_deaths", bus.o_deaths, 1);
        chk("lava_move",   bus.o_move_en, 0);
        ticks(15);
        chk("dying_15", bus.o_state, 2);
        tick();
        chk("respawn_state", bus.o_state, 1);
        chk("respawn_load",  bus.o_spawn_load, 1);
        chk("respawn_sx",    bus.o_spawn_x, 304);
        chk("respawn_sy",    bus.o_spawn_y, 220);
        step();
        chk("respawn_load_1cyc", bus.o_spawn_load, 0);

        // Checkpoint captured at the tick, then a coincident lava strobe
        bus.i_char_x = 10'd500; bus.i_char_y = 10'd300; bus.i_hit_checkpoint = 1;
        tick();
        bus.i_hit_checkpoint = 0; bus.i_char_x = 10'd100; bus.i_char_y = 10'd100;
        chk("cp_stay_play", bus.o_state, 1);
        step();
        bus.i_hit_lava = 1; tick(); bus.i_hit_lava = 0;
        chk("coinc_lava_state", bus.o_state, 2);
        chk("coinc_lava_deaths", bus.o_deaths, 2);
        ticks(16);
        chk("cp_respawn_sx", bus.o_spawn_x, 500);
        chk("cp_respawn_sy", bus.o_spawn_y, 300);
        chk("cp_respawn_load", bus.o_spawn_load, 1);

        // Exit to level 1 through a full transition
        bus.i_hit_exit = 1; tick(); bus.i_hit_exit = 0;
        chk("trans_state", bus.o_state, 3);
        chk("trans_fade",  bus.o_fade, 1);
        chk("trans_move",  bus.o_move_en, 0);
        ticks(31);
        chk("trans_31", bus.o_state, 3);
        tick();
        chk("trans_done_state", bus.o_state, 1);
        chk("trans_done_level", bus.o_level, 1);
        chk("trans_done_load",  bus.o_spawn_load, 1);
        chk("trans_done_sx",    bus.o_spawn_x, 304);
        chk("trans_done_fade",  bus.o_fade, 0);
        // Checkpoint cleared: next death spawns at the default
        bus.i_hit_lava = 1; tick(); bus.i_hit_lava = 0;
        ticks(16);
        chk("cp_cleared_sx", bus.o_spawn_x, 304);
        chk("cp_cleared_sy", bus.o_spawn_y, 220);

        // Priority: lava and exit in the same frame
        step();
        bus.i_hit_lava = 1; bus.i_hit_exit = 1; step();
        bus.i_hit_lava = 0; bus.i_hit_exit = 0; step();
        tick();
        chk("prio_state",  bus.o_state, 2);
        chk("prio_level",  bus.o_level, 1);
        chk("prio_deaths", bus.o_deaths, 4);
        ticks(16);
        // Start is ignored while playing
        bus.i_start = 1; step();
        chk("start_ignored_level", bus.o_level, 1);
        chk("start_ignored_load",  bus.o_spawn_load, 0);
        bus.i_start = 0; step();

        // Win path
        exit_level();
        exit_level();
        chk("lvl3", bus.o_level, 3);
        bus.i_hit_exit = 1; tick(); bus.i_hit_exit = 0;
        chk("win_state", bus.o_state, 4);
        chk("win_flag",  bus.o_win, 1);
        chk("win_move",  bus.o_move_en, 0);
        bus.i_start = 1; step();
        chk("restart_state",  bus.o_state, 1);
        chk("restart_level",  bus.o_level, 0);
        chk("restart_deaths", bus.o_deaths, 0);
        chk("restart_load",   bus.o_spawn_load, 1);
        chk("restart_win",    bus.o_win, 0);
        bus.i_start = 0; step();

        // Death counter saturation
        for (int d = 0; d < 256; d++) begin
            bus.i_hit_lava = 1; tick(); bus.i_hit_lava = 0;
            ticks(16);
        end
        chk("sat_deaths", bus.o_deaths, 255);
        chk("sat_state",  bus.o_state, 1);

        // Asynchronous reset in the middle of a transition
        bus.i_hit_exit = 1; tick(); bus.i_hit_exit = 0;
        ticks(5);
        chk("pre_rst_trans", bus.o_state, 3);
        #2 rst = 1'b1;
        #1;
        chk("arst_state", bus.o_state, 0);
        chk("arst_fade",  bus.o_fade, 0);
        chk("arst_load",  bus.o_spawn_load, 0);
        chk("arst_level", bus.o_level, 0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_load",  bus.o_spawn_load, 0);
        chk("post_rst_state", bus.o_state, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/game_sequencer.md
# game_sequencer

Frame-rate game state machine that sequences the character/level datapath of the VGA game. It collects per-pixel collision strobes from the level renderer during each frame and evaluates them once per frame at `frame_tick`. From that evaluation it drives the current level index, movement enable, respawn loads (default or checkpoint position), the death counter and the transition/win indicators. The block sits between the VGA timing generator, the level renderer and the character movement logic.

## Interface
- `NUM_LEVELS`, 4: number of levels, 1..8. Level index runs 0..NUM_LEVELS-1.
- `DEATH_FRAMES`, 16: frame ticks spent in DYING. Must be ≥1.
- `TRANS_FRAMES`, 32: frame ticks spent in TRANSIT. Must be ≥1.
- `SPAWN_X`, 304: default spawn x, 10 bits.
- `SPAWN_Y`, 220: default spawn y, 10 bits.

- `clk` in 1: system clock. All state is updated on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `frame_tick` in 1: one-cycle pulse once per frame, at the start of vertical blanking.
- `start` in 1: start button, level signal, already debounced.
- `hit_lava` in 1: strobe; character pixel overlaps lava.
- `hit_exit` in 1: strobe; character pixel overlaps the level exit region.
- `hit_checkpoint` in 1: strobe; character pixel overlaps a checkpoint.
- `char_x`, `char_y` in 10 each: current character center position.
- `level` out 3: current level index.
- `state` out 3: IDLE=0, PLAY=1, DYING=2, TRANSIT=3, WIN=4.
- `move_en` out 1: movement logic may update position.
- `spawn_load` out 1: one-cycle pulse; movement logic loads `spawn_x`/`spawn_y`.
- `spawn_x`, `spawn_y` out 10 each: respawn position.
- `deaths` out 8: death count, saturates at 255.
- `fade` out 1: high in TRANSIT.
- `win` out 1: high in WIN.

## Operation
- **Reset values:** state=IDLE, level=0, deaths=0, move_en=0, spawn_load=0, spawn_x/y=SPAWN_X/Y, fade=0, win=0. Also at reset: checkpoint invalid, hit latches clear, frame counter 0, start edge register=1 (a button held through reset does not start the game).
- **Start edge:** `start_rise` = start & ~start_q, registered each cycle.
- **Hit latches:**
  - Sticky lava/exit/checkpoint latches set by the strobes while state=PLAY.
  - Evaluation uses latch OR live strobe, so a strobe coincident with `frame_tick` counts.
  - All latches clear on every `frame_tick`, and are held clear outside PLAY.
- **IDLE:** on `start_rise`, go to PLAY with level=0, deaths=0, checkpoint invalid, spawn_x/y=SPAWN_X/Y and a spawn_load pulse.
- **PLAY:** move_en=1. At `frame_tick`, evaluate in priority order: lava > exit > checkpoint.
  - Lava: go to DYING, deaths+1 (saturating), frame counter=0.
  - Exit with level<NUM_LEVELS-1: go to TRANSIT, frame counter=0.
  - Exit with level=NUM_LEVELS-1: go to WIN.
  - Checkpoint only: capture char_x/char_y into checkpoint registers, set checkpoint valid, stay in PLAY.
- **DYING:** move_en=0. Count frame_ticks. On the DEATH_FRAMES-th tick, go to PLAY with a spawn_load pulse.
  - spawn_x/y = checkpoint position if valid, else SPAWN_X/Y.
- **TRANSIT:** move_en=0, fade=1. On the TRANS_FRAMES-th tick, go to PLAY with level+1, checkpoint invalid, spawn_x/y=SPAWN_X/Y and a spawn_load pulse.
- **WIN:** move_en=0, win=1. `start_rise` behaves exactly as in IDLE (full restart).
- `start` is ignored in PLAY, DYING and TRANSIT.

## Timing
- All outputs are registered.
- The state change, level change, spawn_x/y update and spawn_load assertion happen on the same edge, and are visible the cycle after the triggering `frame_tick` or `start_rise` cycle.
- spawn_load is high for exactly one cycle per respawn or start.
- DYING lasts exactly DEATH_FRAMES frame_ticks after entry. The entry tick is not counted.
- TRANSIT lasts exactly TRANS_FRAMES frame_ticks after entry. The entry tick is not counted.
- A checkpoint capture uses char_x/char_y sampled in the `frame_tick` cycle.
- An asynchronous `rst` mid-DYING or mid-TRANSIT returns the block to IDLE immediately. No spawn_load pulse is generated.
- The deaths counter holds at 255 on further deaths.

## Test plan
- **Start:** reset with start held high → stays IDLE. Release start, then assert it → next cycle state=1, level=0, spawn_load pulses once, spawn=(304,220), move_en=1.
- **Lava death:** in PLAY, hit_lava pulsed mid-frame → at next frame_tick state=2, deaths=1, move_en=0. Exactly 16 ticks later state=1 with spawn_load and spawn=(304,220).
- **Checkpoint:** hit_checkpoint with char=(500,300) at a frame_tick, then lava → respawn at (500,300). Then exit plus 32 ticks → level=1, spawn=(304,220), checkpoint cleared.
- **Priority:** hit_lava and hit_exit in the same frame → DYING, level unchanged. A strobe coincident with frame_tick is honored.
- **Win:** exit on level 3 → state=4, win=1. start_rise → level=0, deaths=0, PLAY.
- **Saturation and reset:** 256 deaths → deaths stays 255. rst asserted mid-TRANSIT → state=0, fade=0, no spawn_load.
